// File: rtl/ram_1p_arbiter_if.sv
// Host-side and SRAM-side signal bundle of the single-port RAM arbiter.
// Latency: none (wires only); the arbiter defines all timing.
// Backpressure: req/gnt; a host holds req and attributes until granted.
//
// Signals:
//   a_*/b_*  : host A / host B request (req, we, addr, wdata, wmask), grant,
//              read response (rvalid, rdata)
//   mem_*    : SRAM pins (req, write, addr, wdata, wmask) and returned rdata
// Modports:
//   slave    : the arbiter
//   master   : the environment (hosts + SRAM)
interface ram_1p_arbiter_if #(
    parameter int Width = 32,
    parameter int Depth = 2048
);
    localparam int Aw = $clog2(Depth);

    logic             a_req_i;
    logic             a_we_i;
    logic [Aw-1:0]    a_addr_i;
    logic [Width-1:0] a_wdata_i;
    logic [Width-1:0] a_wmask_i;
    logic             a_gnt_o;
    logic             a_rvalid_o;
    logic [Width-1:0] a_rdata_o;

    logic             b_req_i;
    logic             b_we_i;
    logic [Aw-1:0]    b_addr_i;
    logic [Width-1:0] b_wdata_i;
    logic [Width-1:0] b_wmask_i;
    logic             b_gnt_o;
    logic             b_rvalid_o;
    logic [Width-1:0] b_rdata_o;

    logic             mem_req_o;
    logic             mem_write_o;
    logic [Aw-1:0]    mem_addr_o;
    logic [Width-1:0] mem_wdata_o;
    logic [Width-1:0] mem_wmask_o;
    logic [Width-1:0] mem_rdata_i;

    modport slave (
        input  a_req_i, a_we_i, a_addr_i, a_wdata_i, a_wmask_i,
        output a_gnt_o, a_rvalid_o, a_rdata_o,
        input  b_req_i, b_we_i, b_addr_i, b_wdata_i, b_wmask_i,
        output b_gnt_o, b_rvalid_o, b_rdata_o,
        output mem_req_o, mem_write_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
        input  mem_rdata_i
    );

    modport master (
        output a_req_i, a_we_i, a_addr_i, a_wdata_i, a_wmask_i,
        input  a_gnt_o, a_rvalid_o, a_rdata_o,
        output b_req_i, b_we_i, b_addr_i, b_wdata_i, b_wmask_i,
        input  b_gnt_o, b_rvalid_o, b_rdata_o,
        input  mem_req_o, mem_write_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/ram_1p_arbiter.sv
// Two-host round-robin arbiter in front of one single-port SRAM, with post-reset zero-fill.
// Latency: grant same cycle (combinational); read data/rvalid one cycle after grant.
// Backpressure: gnt low holds the host off; no buffering, host keeps req stable until gnt.
//
// Ports:
//   clk_i        : clock, all state on rising edge
//   rst_i        : synchronous active-high reset, restarts the zero-fill
//   init_done_o  : registered, high once every SRAM word has been zeroed
//   bus (slave)  : host A/B request/grant/response and SRAM pins
module ram_1p_arbiter #(
    parameter int Width = 32,
    parameter int Depth = 2048
) (
    input  logic                clk_i,
    input  logic                rst_i,
    output logic                init_done_o,
    ram_1p_arbiter_if.slave     bus
);
    localparam int Aw = $clog2(Depth);
    localparam logic [Aw-1:0] LastAddr = Aw'(Depth - 1);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic             we;
        logic [Aw-1:0]    addr;
        logic [Width-1:0] wdata;
        logic [Width-1:0] wmask;
    } mem_cmd_t;

    state_e        state_q;
    logic [Aw-1:0] fill_cnt_q;
    logic          rr_q;        // 0: A wins a tie, 1: B wins a tie
    logic          init_done_q;
    logic          a_rvalid_q;
    logic          b_rvalid_q;

    logic          a_gnt;
    logic          b_gnt;
    mem_cmd_t      a_cmd;
    mem_cmd_t      b_cmd;
    mem_cmd_t      win_cmd;

    always_comb begin
        a_cmd = '{we: bus.a_we_i, addr: bus.a_addr_i,
                  wdata: bus.a_wdata_i, wmask: bus.a_wmask_i};
        b_cmd = '{we: bus.b_we_i, addr: bus.b_addr_i,
                  wdata: bus.b_wdata_i, wmask: bus.b_wmask_i};
    end

    // Grants exist only in RUN; the pointer only matters when both ask.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (state_q == RUN) begin
            if (bus.a_req_i && (!bus.b_req_i || !rr_q)) begin
                a_gnt = 1'b1;
            end else if (bus.b_req_i) begin
                b_gnt = 1'b1;
            end
        end
    end

    assign win_cmd = b_gnt ? b_cmd : a_cmd;

    // SRAM pin mux: fill writes own the port in INIT, the winner owns it in RUN.
    always_comb begin
        bus.mem_req_o   = 1'b0;
        bus.mem_write_o = 1'b0;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        bus.mem_wmask_o = '0;
        if (state_q == INIT) begin
            bus.mem_req_o   = 1'b1;
            bus.mem_write_o = 1'b1;
            bus.mem_addr_o  = fill_cnt_q;
            bus.mem_wdata_o = '0;
            bus.mem_wmask_o = '1;
        end else begin
            bus.mem_req_o   = a_gnt | b_gnt;
            bus.mem_write_o = win_cmd.we;
            bus.mem_addr_o  = win_cmd.addr;
            bus.mem_wdata_o = win_cmd.wdata;
            bus.mem_wmask_o = win_cmd.wmask;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= INIT;
            fill_cnt_q  <= '0;
            rr_q        <= 1'b0;
            init_done_q <= 1'b0;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    a_rvalid_q <= 1'b0;
                    b_rvalid_q <= 1'b0;
                    fill_cnt_q <= fill_cnt_q + Aw'(1);
                    if (fill_cnt_q == LastAddr) begin
                        state_q     <= RUN;
                        init_done_q <= 1'b1;
                    end
                end
                RUN: begin
                    // SRAM returns read data one cycle after the request.
                    a_rvalid_q <= a_gnt & ~bus.a_we_i;
                    b_rvalid_q <= b_gnt & ~bus.b_we_i;
                    // Point at the loser so a persistent competitor goes next.
                    if (a_gnt) begin
                        rr_q <= 1'b1;
                    end else if (b_gnt) begin
                        rr_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= INIT;
                end
            endcase
        end
    end

    assign init_done_o    = init_done_q;
    assign bus.a_gnt_o    = a_gnt;
    assign bus.b_gnt_o    = b_gnt;
    assign bus.a_rvalid_o = a_rvalid_q;
    assign bus.b_rvalid_o = b_rvalid_q;
    assign bus.a_rdata_o  = a_rvalid_q ? bus.mem_rdata_i : '0;
    assign bus.b_rdata_o  = b_rvalid_q ? bus.mem_rdata_i : '0;

endmodule

// File: tb/tb_ram_1p_arbiter.sv
// Bench for ram_1p_arbiter: directed scenarios then random traffic against a reference model.
// Latency: model expects same-cycle grant and one-cycle read response.
// Backpressure: bench hosts hold each request until the model says it is granted.
module tb_ram_1p_arbiter;
    localparam int W = 32;
    localparam int D = 16;
    localparam int AW = $clog2(D);

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic init_done_o;

    always #5 clk = ~clk;

    ram_1p_arbiter_if #(.Width(W), .Depth(D)) bus ();

    ram_1p_arbiter #(.Width(W), .Depth(D)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .init_done_o (init_done_o),
        .bus         (bus)
    );

    // SRAM behaviour: masked write, registered read. Starts with garbage so
    // the zero-fill is observable.
    logic [W-1:0] sram [D];
    logic [W-1:0] sram_rdata;
    logic         scramble = 1'b1;

    always @(posedge clk) begin
        if (scramble) begin
            for (int i = 0; i < D; i++) sram[i] <= $urandom;
        end else if (bus.mem_req_o) begin
            if (bus.mem_write_o)
                sram[bus.mem_addr_o] <= (sram[bus.mem_addr_o] & ~bus.mem_wmask_o)
                                      | (bus.mem_wdata_o & bus.mem_wmask_o);
            else
                sram_rdata <= sram[bus.mem_addr_o];
        end
    end
    assign bus.mem_rdata_i = sram_rdata;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: what memory should hold and what each cycle should show.
    logic [W-1:0] exp_mem [D];
    bit           filled;
    int           fill_idx;
    bit           ptr_b;        // tie goes to B when set
    bit           pend_a, pend_b;
    logic [W-1:0] pend_a_dat, pend_b_dat;

    // Host drivers.
    bit            a_req, b_req, a_we, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [W-1:0]  a_wdata, b_wdata, a_wmask, b_wmask;
    bit            a_sticky, b_sticky, rand_mode;

    function automatic logic [W-1:0] rand_mask();
        logic [W-1:0] m;
        m = ($urandom_range(0, 1) == 1) ? '1 : W'($urandom);
        return m;
    endfunction

    task automatic gen_a();
        a_req = 1; a_we = 1'($urandom_range(0, 1)); a_addr = AW'($urandom_range(0, D - 1));
        a_wdata = $urandom; a_wmask = rand_mask();
    endtask

    task automatic gen_b();
        b_req = 1; b_we = 1'($urandom_range(0, 1)); b_addr = AW'($urandom_range(0, D - 1));
        b_wdata = $urandom; b_wmask = rand_mask();
    endtask

    task automatic step(input bit rst);
        int win;
        bit npa, npb;
        logic [W-1:0] npa_dat, npb_dat;
        rst_i = rst;
        bus.a_req_i = rst ? 1'b0 : a_req; bus.a_we_i = a_we; bus.a_addr_i = a_addr;
        bus.a_wdata_i = a_wdata; bus.a_wmask_i = a_wmask;
        bus.b_req_i = rst ? 1'b0 : b_req; bus.b_we_i = b_we; bus.b_addr_i = b_addr;
        bus.b_wdata_i = b_wdata; bus.b_wmask_i = b_wmask;
        #1;
        win = -1;
        if (!rst) begin
            check("init_done", W'(init_done_o), W'(filled));
            if (!filled) begin
                check("fill_req",   W'(bus.mem_req_o),   W'(1));
                check("fill_write", W'(bus.mem_write_o), W'(1));
                check("fill_addr",  W'(bus.mem_addr_o),  W'(fill_idx));
                check("fill_wdata", bus.mem_wdata_o, '0);
                check("fill_wmask", bus.mem_wmask_o, '1);
                check("init_a_gnt", W'(bus.a_gnt_o), W'(0));
                check("init_b_gnt", W'(bus.b_gnt_o), W'(0));
            end else begin
                if (a_req && b_req) win = ptr_b ? 1 : 0;
                else if (a_req)     win = 0;
                else if (b_req)     win = 1;
                check("a_gnt",   W'(bus.a_gnt_o),   W'(win == 0));
                check("b_gnt",   W'(bus.b_gnt_o),   W'(win == 1));
                check("mem_req", W'(bus.mem_req_o), W'(win >= 0));
                if (win >= 0) begin
                    check("mem_write", W'(bus.mem_write_o), W'(win == 0 ? a_we : b_we));
                    check("mem_addr",  W'(bus.mem_addr_o),  W'(win == 0 ? a_addr : b_addr));
                    if ((win == 0 ? a_we : b_we)) begin
                        check("mem_wdata", bus.mem_wdata_o, win == 0 ? a_wdata : b_wdata);
                        check("mem_wmask", bus.mem_wmask_o, win == 0 ? a_wmask : b_wmask);
                    end
                end
            end
            check("a_rvalid", W'(bus.a_rvalid_o), W'(pend_a));
            check("b_rvalid", W'(bus.b_rvalid_o), W'(pend_b));
            check("a_rdata",  bus.a_rdata_o, pend_a ? pend_a_dat : '0);
            check("b_rdata",  bus.b_rdata_o, pend_b ? pend_b_dat : '0);
        end

        if (rst) begin
            filled = 0; fill_idx = 0; ptr_b = 0; pend_a = 0; pend_b = 0;
            if (rand_mode) begin a_req = 0; b_req = 0; end
        end else begin
            npa = 0; npb = 0; npa_dat = '0; npb_dat = '0;
            if (!filled) begin
                exp_mem[fill_idx] = '0;
                fill_idx++;
                if (fill_idx == D) filled = 1;
            end else if (win == 0) begin
                if (a_we) exp_mem[a_addr] = (exp_mem[a_addr] & ~a_wmask) | (a_wdata & a_wmask);
                else begin npa = 1; npa_dat = exp_mem[a_addr]; end
                ptr_b = 1;
            end else if (win == 1) begin
                if (b_we) exp_mem[b_addr] = (exp_mem[b_addr] & ~b_wmask) | (b_wdata & b_wmask);
                else begin npb = 1; npb_dat = exp_mem[b_addr]; end
                ptr_b = 0;
            end
            pend_a = npa; pend_a_dat = npa_dat;
            pend_b = npb; pend_b_dat = npb_dat;
            if (win == 0 && !a_sticky) a_req = 0;
            if (win == 1 && !b_sticky) b_req = 0;
            if (rand_mode && !a_req && $urandom_range(0, 9) < 6) gen_a();
            if (rand_mode && !b_req && $urandom_range(0, 9) < 6) gen_b();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input bit we, input int addr, input logic [W-1:0] wd);
        a_req = 1; a_we = we; a_addr = AW'(addr); a_wdata = wd; a_wmask = '1;
    endtask

    task automatic set_b(input bit we, input int addr, input logic [W-1:0] wd);
        b_req = 1; b_we = we; b_addr = AW'(addr); b_wdata = wd; b_wmask = '1;
    endtask

    initial begin
        a_req = 0; b_req = 0; a_we = 0; b_we = 0; a_addr = '0; b_addr = '0;
        a_wdata = '0; b_wdata = '0; a_wmask = '0; b_wmask = '0;
        a_sticky = 0; b_sticky = 0; rand_mode = 0;
        filled = 0; fill_idx = 0; ptr_b = 0; pend_a = 0; pend_b = 0;
        pend_a_dat = '0; pend_b_dat = '0;
        for (int i = 0; i < D; i++) exp_mem[i] = 'x;
        rst_i = 1;
        @(posedge clk);
        #1;
        scramble = 0;

        // Reset, then full zero-fill with no traffic and a couple of idle cycles.
        step(1); step(1);
        repeat (D + 2) step(0);

        // A writes then reads address 5.
        set_a(1, 5, 32'hDEADBEEF); step(0);
        set_a(0, 5, '0);           step(0);
        step(0);

        // A and B hold reads continuously: grants alternate.
        set_a(0, 1, '0); set_b(0, 2, '0); a_sticky = 1; b_sticky = 1;
        repeat (8) step(0);
        a_req = 0; b_req = 0; a_sticky = 0; b_sticky = 0;
        step(0);

        // B reads never-written address 3 from reset: held off through INIT.
        step(1);
        set_b(0, 3, '0);
        repeat (D + 2) step(0);

        // Reset at fill address 7 restarts the fill from 0.
        step(1);
        repeat (7) step(0);
        step(1);
        repeat (D + 1) step(0);

        // Reset the cycle after an A read grant drops the pending rvalid.
        set_a(0, 5, '0); step(0);
        step(1);
        repeat (D + 1) step(0);

        // Random traffic with occasional reset.
        rand_mode = 1;
        for (int c = 0; c < 1500; c++) step($urandom_range(0, 299) == 0);
        rand_mode = 0; a_req = 0; b_req = 0;
        step(0); step(0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ram_1p_arbiter.md
RAM_1P_ARBITER -- requirements
Module: ram_1p_arbiter

Interface
- REQ-001: Parameter Width, default 32, data width in bits of the shared single-port SRAM.
- REQ-002: Parameter Depth, default 2048, number of SRAM words.
- REQ-003: Localparam Aw = $clog2(Depth), address width.
- REQ-004: clk_i  input  1  sole clock; all state updates on rising edge.
- REQ-005: rst_i  input  1  reset, synchronous and active-high.
- REQ-006: init_done_o  output  1  high once the post-reset zero-fill of the SRAM is complete.
- REQ-007: a_req_i / b_req_i  input  1  access request from host A / host B.
- REQ-008: a_we_i / b_we_i  input  1  1 = write, 0 = read.
- REQ-009: a_addr_i / b_addr_i  input  Aw  word address.
- REQ-010: a_wdata_i / b_wdata_i  input  Width  write data.
- REQ-011: a_wmask_i / b_wmask_i  input  Width  per-bit write mask.
- REQ-012: a_gnt_o / b_gnt_o  output  1  request accepted this cycle.
- REQ-013: a_rvalid_o / b_rvalid_o  output  1  read data valid.
- REQ-014: a_rdata_o / b_rdata_o  output  Width  read data.
- REQ-015: mem_req_o, mem_write_o (1), mem_addr_o (Aw), mem_wdata_o, mem_wmask_o (Width)  outputs  drive the SRAM req/write/addr/wdata/wmask pins.
- REQ-016: mem_rdata_i  input  Width  SRAM read data, valid the cycle after a read request.

Function
- REQ-017: FSM states SHALL be INIT and RUN; reset SHALL enter INIT with the fill counter at 0.
- REQ-018: In INIT, the block SHALL drive mem_req_o=1, mem_write_o=1, mem_addr_o=counter, mem_wdata_o=0, mem_wmask_o=all ones each cycle, incrementing the counter by 1.
- REQ-019: When the write to address Depth-1 is issued, the FSM SHALL move to RUN next cycle; init_done_o SHALL be registered and rise on RUN entry, exactly Depth cycles after reset deasserts.
- REQ-020: In INIT, a_gnt_o and b_gnt_o SHALL be 0 regardless of requests.
- REQ-021: In RUN, grant SHALL be combinational and same-cycle: at most one of a_gnt_o/b_gnt_o is high, and only when the matching req is high.
- REQ-022: In RUN, a single requester SHALL be granted immediately.
- REQ-023: If both request, the host indicated by a 1-bit round-robin pointer SHALL win; the pointer is A after reset.
- REQ-024: After any grant the pointer SHALL point to the non-granted host; with no grant it SHALL hold.
- REQ-025: On a grant, mem_* SHALL carry the winner's we/addr/wdata/wmask with mem_req_o=1; with no grant in RUN, mem_req_o=0 and other mem_* outputs are don't-care.
- REQ-026: A host SHALL hold req and its attributes stable until granted; the block does not buffer requests.
- REQ-027: A granted read SHALL assert that host's rvalid_o exactly one cycle later, for one cycle; granted writes produce no rvalid.
- REQ-028: rdata_o SHALL equal mem_rdata_i while the host's rvalid_o is high, and 0 otherwise.
- REQ-029: Back-to-back grants on consecutive cycles SHALL be supported (throughput one access per cycle).

Reset
- REQ-030: On rst_i, next-cycle values SHALL be: state INIT, counter 0, pointer A, init_done_o 0, both rvalid_o 0, both gnt_o 0.
- REQ-031: Reset asserted mid-fill or mid-RUN SHALL abort the current operation, drop any pending rvalid, and restart the zero-fill from address 0.

Verification (Depth=16, Width=32)
- REQ-032: Release reset, no requests -> addresses 0..15 written with 0 and mask 0xFFFFFFFF on 16 consecutive cycles; init_done_o rises on cycle 16; then mem_req_o=0.
- REQ-033: After init, A writes 0xDEADBEEF to addr 5, then reads addr 5 -> a_gnt_o same cycle each time; a_rvalid_o one cycle after read grant with a_rdata_o=0xDEADBEEF; b_rvalid_o stays 0.
- REQ-034: A and B hold reads continuously -> grants alternate A,B,A,B one per cycle; each rvalid follows its grant by one cycle.
- REQ-035: B reads addr 3 (never written) during INIT -> b_gnt_o=0 until RUN; then granted on the first RUN cycle, b_rdata_o=0.
- REQ-036: Assert rst_i at fill address 7 -> next cycle counter 0, init_done_o 0, fill restarts; init_done_o rises 16 cycles after release.
- REQ-037: Assert rst_i the cycle after an A read grant -> a_rvalid_o is 0 on the following cycle.
